// File: rtl/mac_array_acc_if.sv
// Beat-in / result-out bundle of the multi-lane MAC accumulator.
// The testbench side drives the master modport and the accumulator uses the slave modport.
interface mac_array_acc_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16
);
    logic                     clken;
    logic                     in_valid;
    logic                     in_first;
    logic                     in_last;
    logic [LANES*DATA_W-1:0]  dataa;
    logic [LANES*DATA_W-1:0]  datab;
    logic signed [ACC_W-1:0]  sumin;
    logic signed [OUT_W-1:0]  result;
    logic                     out_valid;
    logic                     overflow;

    modport master (
        output clken, in_valid, in_first, in_last, dataa, datab, sumin,
        input  result, out_valid, overflow
    );

    modport slave (
        input  clken, in_valid, in_first, in_last, dataa, datab, sumin,
        output result, out_valid, overflow
    );
endinterface

// File: rtl/mac_array_acc.sv
// LANES parallel signed multipliers, an adder tree and a windowed accumulator.
// Each window is seeded with a bias; the total is shifted and saturated to OUT_W.
module mac_array_acc #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic             clock,
    input  logic             aclr,
    mac_array_acc_if.slave   bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [PROD_W-1:0] prod_c  [LANES];
    logic signed [PROD_W-1:0] prod_s1 [LANES];
    logic                     v1, f1, l1;
    logic signed [ACC_W-1:0]  sumin_s1;

    logic signed [ACC_W-1:0]  lanesum_c;
    logic signed [ACC_W-1:0]  lanesum_s2;
    logic signed [ACC_W-1:0]  sumin_s2;
    logic                     v2, f2, l2;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     fire3;
    logic signed [ACC_W-1:0]  shifted;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_c[i] = PROD_W'($signed(bus.dataa[i*DATA_W +: DATA_W]))
                      * PROD_W'($signed(bus.datab[i*DATA_W +: DATA_W]));
        end
    end

    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            for (int i = 0; i < LANES; i++) prod_s1[i] <= '0;
            v1       <= 1'b0;
            f1       <= 1'b0;
            l1       <= 1'b0;
            sumin_s1 <= '0;
        end else if (bus.clken) begin
            for (int i = 0; i < LANES; i++) prod_s1[i] <= prod_c[i];
            v1       <= bus.in_valid;
            f1       <= bus.in_first;
            l1       <= bus.in_last;
            sumin_s1 <= bus.sumin;
        end
    end

    // Products are sign-extended to the accumulator width before summing so no tree level can overflow.
    always_comb begin
        lanesum_c = '0;
        for (int i = 0; i < LANES; i++) begin
            lanesum_c = lanesum_c + ACC_W'(prod_s1[i]);
        end
    end

    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            lanesum_s2 <= '0;
            sumin_s2   <= '0;
            v2         <= 1'b0;
            f2         <= 1'b0;
            l2         <= 1'b0;
        end else if (bus.clken) begin
            lanesum_s2 <= lanesum_c;
            sumin_s2   <= sumin_s1;
            v2         <= v1;
            f2         <= f1;
            l2         <= l1;
        end
    end

    assign acc_next = f2 ? (sumin_s2 + lanesum_s2) : (acc + lanesum_s2);

    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            acc   <= '0;
            fire3 <= 1'b0;
        end else if (bus.clken) begin
            if (v2) acc <= acc_next;
            fire3 <= v2 && l2;
        end
    end

    assign shifted = acc >>> SHIFT;

    // Result keeps its last value between windows; only the valid/overflow flags drop.
    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            bus.result    <= '0;
            bus.out_valid <= 1'b0;
            bus.overflow  <= 1'b0;
        end else if (bus.clken) begin
            bus.out_valid <= fire3;
            if (fire3) begin
                if (shifted > MAX_V) begin
                    bus.result   <= MAX_V[OUT_W-1:0];
                    bus.overflow <= 1'b1;
                end else if (shifted < MIN_V) begin
                    bus.result   <= MIN_V[OUT_W-1:0];
                    bus.overflow <= 1'b1;
                end else begin
                    bus.result   <= shifted[OUT_W-1:0];
                    bus.overflow <= 1'b0;
                end
            end else begin
                bus.overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_array_acc.sv
// Bench for mac_array_acc: two instances (SHIFT=0 and SHIFT=2) share one stimulus stream
// and are compared against a window-level arithmetic model.
`timescale 1ns/1ps
module tb_mac_array_acc;
    typedef struct packed {
        int                 cyc;
        logic               v0;
        logic signed [15:0] r0;
        logic               o0;
        logic               v2;
        logic signed [15:0] r2;
        logic               o2;
    } ent_t;

    logic clock = 1'b0;
    logic aclr;

    mac_array_acc_if #(.DATA_W(8), .LANES(4), .ACC_W(32), .OUT_W(16)) ifa ();
    mac_array_acc_if #(.DATA_W(8), .LANES(4), .ACC_W(32), .OUT_W(16)) ifb ();

    assign ifb.clken    = ifa.clken;
    assign ifb.in_valid = ifa.in_valid;
    assign ifb.in_first = ifa.in_first;
    assign ifb.in_last  = ifa.in_last;
    assign ifb.dataa    = ifa.dataa;
    assign ifb.datab    = ifa.datab;
    assign ifb.sumin    = ifa.sumin;

    mac_array_acc #(.DATA_W(8), .LANES(4), .ACC_W(32), .OUT_W(16), .SHIFT(0)) dut0 (
        .clock(clock), .aclr(aclr), .bus(ifa));
    mac_array_acc #(.DATA_W(8), .LANES(4), .ACC_W(32), .OUT_W(16), .SHIFT(2)) dut2 (
        .clock(clock), .aclr(aclr), .bus(ifb));

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int en_cycle = 0;
    ent_t exp_q[$];
    ent_t obs_q[$];
    logic signed [31:0] model_acc = '0;

    // Every enabled edge is counted; any out_valid seen just after it is logged with that count.
    always @(posedge clock) begin
        ent_t o;
        if (aclr && ifa.clken) begin
            en_cycle++;
            #1;
            if (ifa.out_valid || ifb.out_valid) begin
                o.cyc = en_cycle;
                o.v0 = ifa.out_valid; o.r0 = ifa.result; o.o0 = ifa.overflow;
                o.v2 = ifb.out_valid; o.r2 = ifb.result; o.o2 = ifb.overflow;
                obs_q.push_back(o);
            end
        end
    end

    function automatic logic [31:0] pack4(input int x0, input int x1, input int x2, input int x3);
        return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
    endfunction

    function automatic logic signed [31:0] model_lanes(input logic [31:0] a, input logic [31:0] b);
        int s = 0;
        for (int i = 0; i < 4; i++) s += int'($signed(a[i*8 +: 8])) * int'($signed(b[i*8 +: 8]));
        return s;
    endfunction

    function automatic logic [16:0] sat(input logic signed [31:0] acc, input int sh);
        longint s;
        s = longint'(acc) >>> sh;
        if (s > 32767)  return {1'b1, 16'h7fff};
        if (s < -32768) return {1'b1, 16'h8000};
        return {1'b0, s[15:0]};
    endfunction

    task automatic beat(input logic v, input logic f, input logic l, input logic [31:0] a,
                        input logic [31:0] b, input logic signed [31:0] s, input logic en);
        logic [16:0] x0, x2;
        @(negedge clock);
        ifa.clken = en; ifa.in_valid = v; ifa.in_first = f; ifa.in_last = l;
        ifa.dataa = a; ifa.datab = b; ifa.sumin = s;
        if (en && v) begin
            if (f) model_acc = s + model_lanes(a, b);
            else   model_acc = model_acc + model_lanes(a, b);
            if (l) begin
                x0 = sat(model_acc, 0);
                x2 = sat(model_acc, 2);
                exp_q.push_back('{cyc: en_cycle + 4, v0: 1'b1, r0: x0[15:0], o0: x0[16],
                                  v2: 1'b1, r2: x2[15:0], o2: x2[16]});
            end
        end
    endtask

    task automatic flush(input int n);
        repeat (n) beat(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    endtask

    task automatic test_reset_state();
        aclr = 1'b0;
        ifa.clken = 1'b0; ifa.in_valid = 1'b0; ifa.in_first = 1'b0; ifa.in_last = 1'b0;
        ifa.dataa = '0; ifa.datab = '0; ifa.sumin = '0;
        #3;
        total++;
        if ({ifa.result, ifa.out_valid, ifa.overflow} !== 18'd0) begin
            bad++; $display("FAIL reset_state_s0 got=%h want=0", {ifa.result, ifa.out_valid, ifa.overflow});
        end
        total++;
        if ({ifb.result, ifb.out_valid, ifb.overflow} !== 18'd0) begin
            bad++; $display("FAIL reset_state_s2 got=%h want=0", {ifb.result, ifb.out_valid, ifb.overflow});
        end
        @(negedge clock);
        aclr = 1'b1;
        model_acc = '0;
    endtask

    task automatic test_single_beat();
        beat(1'b1, 1'b1, 1'b1, pack4(1, 2, 3, 4), pack4(2, 2, 2, 2), 3, 1'b1);
        flush(6);
        total++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            bad++; $display("FAIL single_count got=%0d want=1 model=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i] || obs_q[i].r0 !== 16'sd23) begin
                bad++; $display("FAIL single_entry got=%h want=%h", obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_three_beat();
        beat(1'b1, 1'b1, 1'b0, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), -5, 1'b1);
        beat(1'b1, 1'b0, 1'b0, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 77, 1'b1);
        beat(1'b1, 1'b0, 1'b1, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 99, 1'b1);
        flush(6);
        total++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            bad++; $display("FAIL three_count got=%0d want=1 model=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i] || obs_q[i].r0 !== 16'sd7) begin
                bad++; $display("FAIL three_entry got=%h want=%h", obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_stall();
        beat(1'b1, 1'b1, 1'b0, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), -5, 1'b1);
        beat(1'b1, 1'b0, 1'b0, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 0, 1'b1);
        beat(1'b1, 1'b1, 1'b1, pack4(90, 90, 90, 90), pack4(9, 9, 9, 9), 1234, 1'b0);
        beat(1'b1, 1'b1, 1'b1, pack4(90, 90, 90, 90), pack4(9, 9, 9, 9), 1234, 1'b0);
        beat(1'b1, 1'b0, 1'b1, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 0, 1'b1);
        flush(3);
        @(negedge clock);
        ifa.clken = 1'b0;
        @(posedge clock);
        #1;
        total++;
        if (ifa.out_valid !== 1'b1 || ifa.result !== 16'sd7) begin
            bad++; $display("FAIL stall_hold got=%b/%0d want=1/7", ifa.out_valid, ifa.result);
        end
        flush(6);
        total++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            bad++; $display("FAIL stall_count got=%0d want=1 model=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i] || obs_q[i].r0 !== 16'sd7) begin
                bad++; $display("FAIL stall_entry got=%h want=%h", obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_saturation();
        beat(1'b1, 1'b1, 1'b1, pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), 0, 1'b1);
        beat(1'b1, 1'b1, 1'b1, pack4(127, 127, 127, 127), pack4(-128, -128, -128, -128), 0, 1'b1);
        flush(6);
        total++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            bad++; $display("FAIL sat_count got=%0d want=2 model=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL sat_entry%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() == 2) begin
            total++;
            if ({obs_q[0].r0, obs_q[0].o0, obs_q[1].r0, obs_q[1].o0} !== {16'sd32767, 1'b1, -16'sd32768, 1'b1}) begin
                bad++; $display("FAIL sat_clamp got=%0d/%b %0d/%b want=32767/1 -32768/1",
                                obs_q[0].r0, obs_q[0].o0, obs_q[1].r0, obs_q[1].o0);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        beat(1'b1, 1'b1, 1'b0, pack4(1, 0, 0, 0), pack4(-3, 0, 0, 0), -2, 1'b1);
        beat(1'b1, 1'b0, 1'b1, pack4(-1, 0, 0, 0), pack4(2, 0, 0, 0), 0, 1'b1);
        beat(1'b1, 1'b1, 1'b1, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 5, 1'b1);
        flush(6);
        total++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            bad++; $display("FAIL b2b_count got=%0d want=2 model=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL b2b_entry%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() == 2) begin
            total++;
            if (obs_q[0].r2 !== -16'sd2 || obs_q[1].r2 !== 16'sd2 || obs_q[1].cyc != obs_q[0].cyc + 1) begin
                bad++; $display("FAIL b2b_shift got=%0d,%0d gap=%0d want=-2,2 gap=1",
                                obs_q[0].r2, obs_q[1].r2, obs_q[1].cyc - obs_q[0].cyc);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset();
        beat(1'b1, 1'b1, 1'b1, pack4(3, 3, 3, 3), pack4(5, 5, 5, 5), 40, 1'b1);
        flush(6);
        total++;
        if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            bad++; $display("FAIL rst_pre got=%0d entries want=1 (r0=100)", obs_q.size());
        end
        exp_q.delete(); obs_q.delete();
        beat(1'b1, 1'b1, 1'b0, pack4(7, 7, 7, 7), pack4(7, 7, 7, 7), 500, 1'b1);
        beat(1'b1, 1'b0, 1'b0, pack4(7, 7, 7, 7), pack4(7, 7, 7, 7), 0, 1'b1);
        #2;
        aclr = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_first = 1'b0; ifa.in_last = 1'b0;
        #1;
        total++;
        if ({ifa.result, ifa.out_valid, ifa.overflow, ifb.result, ifb.out_valid, ifb.overflow} !== 36'd0) begin
            bad++; $display("FAIL rst_async got=%0d/%b/%b want=0/0/0", ifa.result, ifa.out_valid, ifa.overflow);
        end
        @(negedge clock);
        aclr = 1'b1;
        model_acc = '0;
        beat(1'b1, 1'b0, 1'b1, pack4(2, 2, 2, 2), pack4(-1, -1, -1, -1), 0, 1'b1);
        beat(1'b1, 1'b1, 1'b1, pack4(1, 2, 3, 4), pack4(2, 2, 2, 2), 3, 1'b1);
        flush(6);
        total++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            bad++; $display("FAIL rst_count got=%0d want=2 model=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL rst_entry%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() == 2) begin
            total++;
            if (obs_q[0].r0 !== -16'sd8 || obs_q[1].r0 !== 16'sd23) begin
                bad++; $display("FAIL rst_fresh got=%0d,%0d want=-8,23", obs_q[0].r0, obs_q[1].r0);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random();
        logic signed [31:0] s;
        for (int n = 0; n < 400; n++) begin
            s = ($urandom_range(0, 3) == 0) ? $urandom : (int'($urandom_range(0, 2000)) - 1000);
            beat($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom, $urandom, s, $urandom_range(0, 7) != 0);
        end
        flush(6);
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL rand_entry%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset_state();
        test_single_beat();
        test_three_beat();
        test_stall();
        test_saturation();
        test_back_to_back();
        test_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
